ram_port_arbiter: RTL

Two-requester arbiter and sequencer for the shared `single_port_sync_ram_large` (32K x 16, bidirectional data bus). Each requester gets a valid/ready command channel and a read-response channel. The block grants the single RAM port round-robin, drives `cs`/`we`/`oe`/`addr`, owns the tristate data bus, and captures read data. It sits between the RAM and its two masters (CPU load/store path at m0, DMA/fill engine at m1).

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/ram_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the two-master RAM port controller.
// Latency: n/a (types only); backpressure: n/a.
package ram_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 15;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves only on accept.
// Latency: combinational grant; backpressure: accept input gates the pointer update.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    master_id_t last;

    // On a tie the master that was not granted most recently wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == M1) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= M1;
        end else if (accept) begin
            last <= grant[1] ? M1 : M0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM between two masters; owns the tristate data bus.
// Latency: write 2 cycles/op, read response 3 cycles after accept; ready only while IDLE.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_t                state, state_nxt;
    master_id_t            owner;
    logic [1:0]            req, grant;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign req    = {m1_req_valid, m0_req_valid};
    assign accept = rst_n && (state == IDLE) && (|req);

    assign m0_req_ready = accept && grant[0];
    assign m1_req_ready = accept && grant[1];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_we    = m0_req_we;
        sel_addr  = m0_req_addr;
        sel_wdata = m0_req_wdata;
        if (grant[1]) begin
            sel_we    = m1_req_we;
            sel_addr  = m1_req_addr;
            sel_wdata = m1_req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = sel_we ? WR : RD1;
            WR:      state_nxt = IDLE;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM controls are derived from the next state so they are clean flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= M0;
            wdata_q      <= '0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_addr     <= '0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_rdata <= '0;
        end else begin
            state        <= state_nxt;
            ram_cs       <= (state_nxt != IDLE);
            ram_we       <= (state_nxt == WR);
            ram_oe       <= (state_nxt == RD1) || (state_nxt == RD2);
            m0_rsp_valid <= (state == RD2) && (owner == M0);
            m1_rsp_valid <= (state == RD2) && (owner == M1);
            if (accept) begin
                owner    <= grant[1] ? M1 : M0;
                ram_addr <= sel_addr;
                wdata_q  <= sel_wdata;
            end
            if (state == RD2 && owner == M0) m0_rsp_rdata <= ram_data;
            if (state == RD2 && owner == M1) m1_rsp_rdata <= ram_data;
        end
    end

    assign ram_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
